toggle_lane_tx: RTL and testbench

TOGGLE_LANE_TX -- requirements
Module: toggle_lane_tx

---
 rtl/toggle_lane_tx_pkg.sv | 42 ++++
 rtl/tt_sync_edge.sv | 22 ++
 rtl/toggle_lane_tx.sv | 138 +++++++++++++
 tb/tb_toggle_lane_tx.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/toggle_lane_tx_pkg.sv
// Shared definitions for the toggle-lane transmitter: FSM encoding, lane indices,
// shadow reset value and lane decode helpers.
package toggle_lane_tx_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StPress = 2'd1,
        StGap   = 2'd2
    } state_e;

    localparam int unsigned NumLanes = 6;

    localparam logic [2:0] Lane0 = 3'd0;
    localparam logic [2:0] Lane1 = 3'd1;
    localparam logic [2:0] Lane2 = 3'd2;
    localparam logic [2:0] Lane3 = 3'd3;
    localparam logic [2:0] Lane4 = 3'd4;
    localparam logic [2:0] Lane5 = 3'd5;

    // Lane 5 idles high on the remote side.
    localparam logic [NumLanes-1:0] ShadowRst = 6'b100000;

    function automatic logic lane_valid(input logic [2:0] lane);
        return lane <= Lane5;
    endfunction

    function automatic logic [NumLanes-1:0] lane_onehot(input logic [2:0] lane);
        logic [NumLanes-1:0] mask;
        mask = '0;
        case (lane)
            Lane0:   mask = 6'b000001;
            Lane1:   mask = 6'b000010;
            Lane2:   mask = 6'b000100;
            Lane3:   mask = 6'b001000;
            Lane4:   mask = 6'b010000;
            Lane5:   mask = 6'b100000;
            default: mask = '0;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/tt_sync_edge.sv
// Two-flop synchronizer for an asynchronous level, followed by a rising-edge
// detector against a third flop.
module tt_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic rise
);

    logic [2:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 3'b000;
        end else begin
            sync_q <= {sync_q[1:0], in};
        end
    end

    assign rise = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/toggle_lane_tx.sv
// Drives press pulses onto one of six remote toggle lanes, tracking the remote
// lane levels in a local shadow so set-mode commands only pulse when needed.
module toggle_lane_tx
    import toggle_lane_tx_pkg::*;
#(
    parameter int unsigned PRESS_CYCLES = 2,
    parameter int unsigned GAP_CYCLES   = 2
) (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

    localparam int unsigned MaxCycles = (PRESS_CYCLES > GAP_CYCLES) ? PRESS_CYCLES : GAP_CYCLES;
    localparam int unsigned CntW      = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;
    localparam logic [CntW-1:0] PressLast = CntW'(PRESS_CYCLES - 1);
    localparam logic [CntW-1:0] GapLast   = CntW'(GAP_CYCLES - 1);

    logic       clk;
    logic       rst;
    logic [2:0] sel;
    logic       req;
    logic       op;
    logic       mode;
    logic       rise;

    assign sel  = io_in[2:0];
    assign clk  = io_in[3];
    assign rst  = io_in[4];
    assign req  = io_in[5];
    assign op   = io_in[6];
    assign mode = io_in[7];

    tt_sync_edge u_sync (
        .clk  (clk),
        .rst  (rst),
        .in   (req),
        .rise (rise)
    );

    state_e                state_q, state_d;
    logic [CntW-1:0]       cyc_q, cyc_d;
    logic [1:0]            rem_q, rem_d;
    logic [2:0]            lane_q, lane_d;
    logic [NumLanes-1:0]   shadow_q, shadow_d;
    logic                  err_q, err_d;
    logic [NumLanes-1:0]   press_q, press_d;
    logic                  busy_q, busy_d;
    logic [1:0]            pulses;

    // Pulse count for the command currently presented on io_in.
    always_comb begin
        pulses = 2'd0;
        if (mode) begin
            pulses = (shadow_q[sel] != op) ? 2'd1 : 2'd0;
        end else begin
            pulses = op ? 2'd2 : 2'd1;
        end
    end

    always_comb begin
        state_d  = state_q;
        cyc_d    = cyc_q;
        rem_d    = rem_q;
        lane_d   = lane_q;
        shadow_d = shadow_q;
        err_d    = err_q;

        unique case (state_q)
            StIdle: begin
                if (rise) begin
                    if (lane_valid(sel)) begin
                        lane_d = sel;
                        rem_d  = pulses;
                        cyc_d  = '0;
                        err_d  = 1'b0;
                        if (pulses != 2'd0) begin
                            state_d = StPress;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StPress: begin
                if (cyc_q == PressLast) begin
                    cyc_d            = '0;
                    rem_d            = rem_q - 2'd1;
                    shadow_d[lane_q] = ~shadow_q[lane_q];
                    state_d          = StGap;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            StGap: begin
                if (cyc_q == GapLast) begin
                    cyc_d   = '0;
                    state_d = (rem_q != 2'd0) ? StPress : StIdle;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs are registered from next state so they line up with the state register.
    always_comb begin
        press_d = (state_d == StPress) ? lane_onehot(lane_d) : '0;
        busy_d  = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cyc_q    <= '0;
            rem_q    <= 2'd0;
            lane_q   <= 3'd0;
            shadow_q <= ShadowRst;
            err_q    <= 1'b0;
            press_q  <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cyc_q    <= cyc_d;
            rem_q    <= rem_d;
            lane_q   <= lane_d;
            shadow_q <= shadow_d;
            err_q    <= err_d;
            press_q  <= press_d;
            busy_q   <= busy_d;
        end
    end

    assign io_out = {err_q, busy_q, press_q};

endmodule

// File: tb/tb_toggle_lane_tx.sv
// Directed bench for toggle_lane_tx: a command table checked cycle by cycle,
// plus hand sequences for busy-discard, mid-press reset and reset priority.
module tb_toggle_lane_tx;

    logic       clk;
    logic       rst;
    logic       req;
    logic       op;
    logic       mode;
    logic [2:0] sel;
    logic [7:0] io_in;
    logic [7:0] io_out;

    int n_checks;
    int n_fail;
    logic err_prev;

    assign io_in = {mode, op, req, rst, clk, sel};

    toggle_lane_tx dut (
        .io_in  (io_in),
        .io_out (io_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [2:0] sel;
        logic       op;
        logic       mode;
        int         pulses;
        int         lane;
        logic       err;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected io_out at the sample following edge N+k, N being the first edge seeing req=1.
    function automatic logic [7:0] exp_out(input int k, input int p, input int lane,
                                           input logic err_now);
        logic       press;
        logic       busy;
        logic [5:0] m;
        press = (p >= 1 && (k == 2 || k == 3)) || (p == 2 && (k == 6 || k == 7));
        busy  = (p > 0) && (k >= 2) && (k < 2 + 4 * p);
        m     = press ? 6'(1 << lane) : 6'b0;
        return {err_now, busy, m};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset_state", {24'b0, io_out}, 32'h0);
        err_prev = 1'b0;
    endtask

    task automatic run_cmd(input string tag, input logic [2:0] s, input logic o, input logic m,
                           input int p, input int lane, input logic e);
        int         rises;
        logic [5:0] prev;
        rises = 0;
        prev  = 6'b0;
        @(negedge clk);
        sel  = s;
        op   = o;
        mode = m;
        req  = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check($sformatf("%s k=%0d", tag, k), {24'b0, io_out},
                  {24'b0, exp_out(k, p, lane, (k >= 2) ? e : err_prev)});
            rises += $countones(io_out[5:0] & ~prev);
            prev  = io_out[5:0];
            // Scramble inputs after acceptance; the command in flight must not change.
            if (k == 2) begin
                sel  = ~s;
                op   = ~o;
                mode = ~m;
            end
        end
        req = 1'b0;
        check($sformatf("%s pulses", tag), rises, p);
        err_prev = e;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int         rises;
        int         highs;
        logic [5:0] prev;

        n_checks = 0;
        n_fail   = 0;
        err_prev = 1'b0;
        rst      = 1'b1;
        req      = 1'b0;
        op       = 1'b0;
        mode     = 1'b0;
        sel      = 3'd0;

        //            sel   op    mode  pulses lane err
        vecs[0]  = '{3'd2, 1'b0, 1'b0, 1, 2, 1'b0};
        vecs[1]  = '{3'd0, 1'b1, 1'b0, 2, 0, 1'b0};
        vecs[2]  = '{3'd5, 1'b1, 1'b1, 0, 5, 1'b0};
        vecs[3]  = '{3'd5, 1'b0, 1'b1, 1, 5, 1'b0};
        vecs[4]  = '{3'd7, 1'b0, 1'b0, 0, 0, 1'b1};
        vecs[5]  = '{3'd1, 1'b0, 1'b0, 1, 1, 1'b0};
        vecs[6]  = '{3'd0, 1'b1, 1'b1, 1, 0, 1'b0};
        vecs[7]  = '{3'd6, 1'b1, 1'b1, 0, 0, 1'b1};
        vecs[8]  = '{3'd2, 1'b1, 1'b1, 0, 2, 1'b0};
        vecs[9]  = '{3'd3, 1'b1, 1'b0, 2, 3, 1'b0};
        vecs[10] = '{3'd4, 1'b0, 1'b1, 0, 4, 1'b0};
        vecs[11] = '{3'd4, 1'b1, 1'b1, 1, 4, 1'b0};

        do_reset();
        for (int i = 0; i < 12; i++) begin
            run_cmd($sformatf("vec%0d", i), vecs[i].sel, vecs[i].op, vecs[i].mode,
                    vecs[i].pulses, vecs[i].lane, vecs[i].err);
        end

        // Second request edge while busy is dropped.
        rises = 0;
        highs = 0;
        prev  = 6'b0;
        @(negedge clk);
        sel  = 3'd1;
        op   = 1'b0;
        mode = 1'b0;
        req  = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            rises += $countones(io_out[5:0] & ~prev);
            highs += $countones(io_out[5:0]);
            prev  = io_out[5:0];
            if (k == 0) req = 1'b0;
            if (k == 1) req = 1'b1;
        end
        req = 1'b0;
        check("busy_drop pulses", rises, 1);
        check("busy_drop high_cycles", highs, 2);
        repeat (4) @(negedge clk);
        check("busy_drop idle", {24'b0, io_out}, 32'h0);

        // Reset during the first PRESS cycle.
        do_reset();
        @(negedge clk);
        sel  = 3'd5;
        op   = 1'b0;
        mode = 1'b0;
        req  = 1'b1;
        repeat (3) @(negedge clk);
        check("mid_press pressing", {24'b0, io_out}, 32'h60);
        rst = 1'b1;
        req = 1'b0;
        @(negedge clk);
        check("mid_press reset", {24'b0, io_out}, 32'h0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        err_prev = 1'b0;
        run_cmd("shadow_after_rst", 3'd5, 1'b1, 1'b1, 0, 5, 1'b0);
        run_cmd("lane5_clear", 3'd5, 1'b0, 1'b1, 1, 5, 1'b0);

        // Reset wins over an edge detected in the same cycle.
        @(negedge clk);
        sel  = 3'd3;
        op   = 1'b0;
        mode = 1'b0;
        req  = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        req = 1'b0;
        @(negedge clk);
        check("rst_priority", {24'b0, io_out}, 32'h0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_priority idle", {24'b0, io_out}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
